// File: rtl/registerfile_mp.sv
// Multi-read-port register file with hardwired-zero entry, write-to-read bypass,
// optional registered read stage and a sequential clear engine.
module registerfile_mp #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 5,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  parameter int READ_LAT = 0
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clr_i,
  output logic                   busy_o,
  input  logic                   we_i,
  input  logic [DEPTH-1:0]       addwrite_i,
  input  logic [WIDTH-1:0]       datowrite_i,
  output logic                   wr_drop_o,
  input  logic [NREAD-1:0]       re_i,
  input  logic [NREAD*DEPTH-1:0] addread_i,
  output logic [NREAD*WIDTH-1:0] datoread_o,
  output logic [NREAD-1:0]       rvalid_o
);

  localparam int NENT = 2 ** DEPTH;

  typedef enum logic {ST_CLEAR, ST_IDLE} state_e;

  state_e           state_q;
  logic [DEPTH-1:0] cnt_q;
  logic             wr_drop_q;
  logic [WIDTH-1:0] mem_q [NENT];

  logic busy;
  logic wr_zero;
  logic wr_en;

  // Clear engine: walks every entry once, then idles until the next request.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_CLEAR;
      cnt_q     <= '0;
      wr_drop_q <= 1'b0;
    end else begin
      wr_drop_q <= 1'b0;
      case (state_q)
        ST_CLEAR: begin
          wr_drop_q <= we_i;
          if (&cnt_q) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + DEPTH'(1);
          end
        end
        default: begin
          if (clr_i) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
          end
        end
      endcase
    end
  end

  assign busy      = (state_q == ST_CLEAR);
  assign busy_o    = busy;
  assign wr_drop_o = wr_drop_q;
  assign wr_zero   = (ZERO_REG != 0) && (addwrite_i == '0);
  assign wr_en     = we_i && !busy && !wr_zero;

  // Storage has no reset; the clear engine is the only way it gets zeroed.
  always_ff @(posedge clk_i) begin
    if (busy) begin
      mem_q[cnt_q] <= '0;
    end else if (wr_en) begin
      mem_q[addwrite_i] <= datowrite_i;
    end
  end

  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [DEPTH-1:0] ra;
    logic [WIDTH-1:0] v;

    assign ra = addread_i[k*DEPTH +: DEPTH];

    always_comb begin
      v = mem_q[ra];
      if (!re_i[k] || busy) begin
        v = '0;
      end else if ((ZERO_REG != 0) && (ra == '0)) begin
        v = '0;
      end else if ((BYPASS != 0) && wr_en && (addwrite_i == ra)) begin
        v = datowrite_i;
      end
    end

    if (READ_LAT == 0) begin : g_comb
      assign datoread_o[k*WIDTH +: WIDTH] = v;
      assign rvalid_o[k]                  = re_i[k];
    end else begin : g_reg
      logic [WIDTH-1:0] rd_q;
      logic             rv_q;

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          rd_q <= '0;
          rv_q <= 1'b0;
        end else begin
          rd_q <= v;
          rv_q <= re_i[k];
        end
      end

      assign datoread_o[k*WIDTH +: WIDTH] = rd_q;
      assign rvalid_o[k]                  = rv_q;
    end
  end

endmodule

// File: tb/tb_registerfile_mp.sv
// Bench for registerfile_mp: two instances (bypass/comb-read and no-bypass/registered-read)
// share stimulus and are compared each cycle against an array-based reference model.
module tb_registerfile_mp;

  localparam int W  = 32;
  localparam int D  = 5;
  localparam int NR = 2;
  localparam int NE = 32;

  logic            clk   = 1'b0;
  logic            rst_n = 1'b0;
  logic            clr   = 1'b0;
  logic            we    = 1'b0;
  logic [D-1:0]    wa    = '0;
  logic [W-1:0]    wd    = '0;
  logic [NR-1:0]   re    = '0;
  logic [NR*D-1:0] ra    = '0;

  logic            busy0, busy1, drop0, drop1;
  logic [NR*W-1:0] rd0, rd1;
  logic [NR-1:0]   rv0, rv1;

  always #5 clk = ~clk;

  registerfile_mp #(.WIDTH(W), .DEPTH(D), .NREAD(NR), .ZERO_REG(1), .BYPASS(1), .READ_LAT(0)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .busy_o(busy0), .we_i(we), .addwrite_i(wa),
    .datowrite_i(wd), .wr_drop_o(drop0), .re_i(re), .addread_i(ra), .datoread_o(rd0), .rvalid_o(rv0)
  );

  registerfile_mp #(.WIDTH(W), .DEPTH(D), .NREAD(NR), .ZERO_REG(1), .BYPASS(0), .READ_LAT(1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .busy_o(busy1), .we_i(we), .addwrite_i(wa),
    .datowrite_i(wd), .wr_drop_o(drop1), .re_i(re), .addread_i(ra), .datoread_o(rd1), .rvalid_o(rv1)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: contents, remaining busy cycles, pending drop flag, registered-read stage.
  logic [W-1:0]  mem_m [NE];
  int            busy_left;
  bit            drop_m;
  logic [W-1:0]  lat_m [NR];
  logic [NR-1:0] rv_m;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    busy_left = NE;
    drop_m    = 1'b0;
    rv_m      = '0;
    for (int i = 0; i < NE; i++) mem_m[i] = '0;
    for (int k = 0; k < NR; k++) lat_m[k] = '0;
  endtask

  function automatic logic [W-1:0] exp_rd(input int k, input bit byp);
    logic [D-1:0] a;
    a = ra[k*D +: D];
    if (!re[k] || busy_left > 0) return '0;
    if (a == '0) return '0;
    if (byp && we && wa == a) return wd;
    return mem_m[a];
  endfunction

  function automatic logic [NR*D-1:0] pk(input int a1, input int a0);
    logic [D-1:0] x1, x0;
    x1 = D'(a1);
    x0 = D'(a0);
    return {x1, x0};
  endfunction

  task automatic cycle(input bit rst, input bit c, input bit w, input int a, input logic [W-1:0] d,
                       input logic [NR-1:0] r, input logic [NR*D-1:0] rad);
    logic [W-1:0] nl [NR];
    bool_dummy: begin end
    @(negedge clk);
    rst_n = rst; clr = c; we = w; wa = D'(a); wd = d; re = r; ra = rad;
    if (!rst) model_reset();
    #2;
    chk("busy0", W'(busy0), W'(busy_left > 0));
    chk("busy1", W'(busy1), W'(busy_left > 0));
    chk("drop0", W'(drop0), W'(drop_m));
    chk("drop1", W'(drop1), W'(drop_m));
    for (int k = 0; k < NR; k++) begin
      chk($sformatf("rd0_p%0d", k), rd0[k*W +: W], exp_rd(k, 1'b1));
      chk($sformatf("rv0_p%0d", k), W'(rv0[k]), W'(re[k]));
      chk($sformatf("rd1_p%0d", k), rd1[k*W +: W], lat_m[k]);
      chk($sformatf("rv1_p%0d", k), W'(rv1[k]), W'(rv_m[k]));
    end
    if (rst) begin
      for (int k = 0; k < NR; k++) nl[k] = exp_rd(k, 1'b0);
      drop_m = (busy_left > 0) && w;
      if (busy_left > 0) begin
        busy_left--;
      end else begin
        if (w && a != 0) mem_m[a] = d;
        if (c) begin
          busy_left = NE;
          for (int i = 0; i < NE; i++) mem_m[i] = '0;
        end
      end
      for (int k = 0; k < NR; k++) lat_m[k] = nl[k];
      rv_m = r;
    end
    @(posedge clk);
  endtask

  task automatic idle(input int n, input logic [NR-1:0] r, input logic [NR*D-1:0] rad);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, 0, '0, r, rad);
  endtask

  initial begin
    model_reset();
    cycle(1'b0, 1'b0, 1'b0, 0, '0, 2'b11, pk(1, 2));
    cycle(1'b0, 1'b0, 1'b0, 0, '0, 2'b11, pk(3, 4));
    // Post-reset clear: 32 busy cycles with reads held at zero.
    for (int i = 0; i < 34; i++) cycle(1'b1, 1'b0, 1'b0, 0, '0, 2'b11, pk(i % NE, (i + 9) % NE));
    for (int i = 0; i < NE; i += 2) idle(1, 2'b11, pk(i + 1, i));
    // Write / read, then partial read enable.
    cycle(1'b1, 1'b0, 1'b1, 5, 32'hDEADBEEF, 2'b00, '0);
    cycle(1'b1, 1'b0, 1'b1, 6, 32'h0000001E, 2'b00, '0);
    idle(1, 2'b11, pk(6, 5));
    idle(1, 2'b01, pk(6, 5));
    // Same-cycle write/read of r7: bypass instance forwards, the other shows the old value.
    cycle(1'b1, 1'b0, 1'b1, 7, 32'h12345678, 2'b01, pk(0, 7));
    idle(2, 2'b11, pk(7, 7));
    // Writes to r0 are discarded without a drop pulse.
    cycle(1'b1, 1'b0, 1'b1, 0, 32'hFFFFFFFF, 2'b01, pk(0, 0));
    idle(2, 2'b11, pk(0, 0));
    // Write during clear is dropped; clear wipes r3.
    cycle(1'b1, 1'b0, 1'b1, 3, 32'h00000011, 2'b00, '0);
    cycle(1'b1, 1'b1, 1'b0, 0, '0, 2'b01, pk(0, 3));
    cycle(1'b1, 1'b0, 1'b1, 3, 32'hAAAA5555, 2'b01, pk(0, 3));
    idle(33, 2'b11, pk(3, 3));
    // Clear plus write in the same idle cycle, then reset in the middle of that clear.
    cycle(1'b1, 1'b0, 1'b1, 9, 32'h0BADF00D, 2'b00, '0);
    cycle(1'b1, 1'b1, 1'b1, 9, 32'hCAFEF00D, 2'b10, pk(9, 0));
    idle(9, 2'b11, pk(9, 9));
    cycle(1'b0, 1'b0, 1'b1, 4, 32'h44444444, 2'b11, pk(9, 4));
    cycle(1'b0, 1'b1, 1'b0, 0, '0, 2'b11, pk(9, 4));
    idle(34, 2'b11, pk(9, 4));
    // Registered read latency and valid.
    cycle(1'b1, 1'b0, 1'b1, 5, 32'hDEADBEEF, 2'b00, '0);
    idle(1, 2'b01, pk(0, 5));
    idle(2, 2'b00, pk(0, 5));
    // Randomised traffic over a small address window to force collisions.
    for (int i = 0; i < 700; i++) begin
      bit rst_b, clr_b, we_b;
      rst_b = ($urandom_range(0, 199) != 0);
      clr_b = ($urandom_range(0, 59) == 0);
      we_b  = $urandom_range(0, 1) == 1;
      cycle(rst_b, clr_b, we_b, $urandom_range(0, 7), $urandom, NR'($urandom_range(0, 3)),
            pk($urandom_range(0, 7), $urandom_range(0, 7)));
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/registerfile_mp.md
Name: registerfile_mp

Overview:
Next-generation general-purpose register file for the 32-bit datapath.
- Generalises the read side to NREAD ports.
- Adds a hardwired-zero option, write-to-read bypass and an optional registered read stage.
- Adds a sequential clear engine that zeroes every entry after reset or on request.
- Sits between decode (read addresses) and writeback (write port).

Parameters:
WIDTH, 32, data width in bits
DEPTH, 5, address width; 2**DEPTH entries
NREAD, 2, number of read ports (1..4)
ZERO_REG, 1, 1 = entry 0 always reads 0 and writes to it are discarded
BYPASS, 1, 1 = a same-cycle write to the addressed entry is forwarded to the read data
READ_LAT, 0, 0 = combinational read; 1 = registered read, one cycle of latency

Ports:
clk_i  in  1  clock; all state changes on the rising edge
rst_ni  in  1  asynchronous, active-low reset
clr_i  in  1  one-cycle request to start a full clear
busy_o  out  1  high while the clear engine runs
we_i  in  1  write enable
addwrite_i  in  DEPTH  write address
datowrite_i  in  WIDTH  write data
wr_drop_o  out  1  pulses for one cycle when a write request is discarded because of busy_o
re_i  in  NREAD  per-port read enable; bit k belongs to port k
addread_i  in  NREAD*DEPTH  read addresses; port k uses bits [k*DEPTH +: DEPTH]
datoread_o  out  NREAD*WIDTH  read data; port k uses bits [k*WIDTH +: WIDTH]
rvalid_o  out  NREAD  per-port valid; equals re_i when READ_LAT=0, re_i delayed one cycle when READ_LAT=1

Behaviour:
- Reset (rst_ni=0, asynchronous): FSM goes to CLEAR with clear counter = 0.
  - busy_o=1, wr_drop_o=0.
  - Registered datoread_o = 0 and rvalid_o = 0 (READ_LAT=1).
  - Array contents are not reset directly; the clear engine zeroes them.
- FSM states: CLEAR, IDLE.
  - CLEAR: each cycle writes 0 to entry[counter], then counter+1.
  - When counter = 2**DEPTH-1 is written, next state is IDLE and the counter returns to 0.
  - A full clear therefore takes exactly 2**DEPTH cycles with busy_o=1.
  - IDLE with clr_i=1: next state is CLEAR, counter = 0.
  - clr_i during CLEAR is ignored; there is no restart.
- Reset asserted mid-CLEAR or mid-IDLE: the clear restarts from entry 0 after release.
- Writes:
  - In IDLE with we_i=1, entry[addwrite_i] <= datowrite_i at the rising edge.
  - If ZERO_REG=1 and addwrite_i=0, the write is silently discarded; no wr_drop_o pulse.
  - In CLEAR, we_i=1 is discarded and wr_drop_o=1 in that cycle (registered: asserts the cycle after the request, lasts 1 cycle).
  - A clr_i and we_i in the same IDLE cycle: the write is performed; the clear starts next cycle and overwrites it.
- Read, port k, value V, evaluated independently per port in this priority order:
  1. re_i[k]=0 → 0
  2. busy_o=1 → 0
  3. ZERO_REG=1 and address=0 → 0
  4. BYPASS=1, we_i=1, addwrite_i = address, and the write is not discarded → datowrite_i
  5. otherwise → entry[address]
- With BYPASS=0, a same-cycle read of the entry being written returns the old value.
- Output timing:
  - READ_LAT=0: datoread_o = V combinationally.
  - READ_LAT=1: datoread_o <= V and rvalid_o[k] <= re_i[k] each cycle. The registered output holds V from the request cycle, including any bypassed value.
- Multiple ports may read the same address; all return identical data.
- No combinational path from rst_ni to datoread_o other than through the registers.

Test Plan:
- Reset clear (DEPTH=5): release rst_ni → busy_o=1 for exactly 32 cycles, then 0. Reads on both ports return 0 throughout. After busy_o falls, every entry reads 0x00000000.
- Write/read: write 0xDEADBEEF to r5 and 0x0000001E to r6; next cycle read port0=r5, port1=r6 → 0xDEADBEEF and 0x0000001E. With re_i=2'b01, port1 reads 0 while port0 still reads 0xDEADBEEF.
- Bypass and zero register:
  - BYPASS=1: write 0x12345678 to r7 while port0 reads r7 in the same cycle → 0x12345678.
  - BYPASS=0: same stimulus → old value.
  - Write 0xFFFFFFFF to r0 → r0 reads 0 and wr_drop_o stays 0.
- Drop during clear: pulse clr_i in IDLE; next cycle write 0xAAAA5555 to r3 → wr_drop_o pulses. After 32 busy cycles, r3 reads 0.
- Reset mid-clear: assert rst_ni low at clear cycle 10 for 2 cycles → busy_o stays 1, then 32 full cycles after release before IDLE.
- READ_LAT=1: read r5 (=0xDEADBEEF) with re_i[0]=1 in cycle N → datoread_o = 0xDEADBEEF and rvalid_o[0]=1 in cycle N+1. Both are 0 in the cycle following re_i=0.
